// File: rtl/decoder_pkg.sv
// decoder_pkg: shared widths and the one-hot helper for the index decoder
package decoder_pkg;
    localparam int DEC_IN_W_DEFAULT  = 3;
    localparam int DEC_OUT_W_DEFAULT = 8;
    // Widest legal decode (IN_W=6); callers narrow the result to their OUT_W.
    function automatic logic [63:0] onehot_of(input logic [5:0] idx);
        return 64'(1) << idx;
    endfunction
endpackage

// File: rtl/decoder_comb.sv
// decoder_comb: combinational index to one-hot (or one-cold) decode
module decoder_comb
    import decoder_pkg::*;
#(
    parameter int IN_W     = DEC_IN_W_DEFAULT,
    parameter int ONE_COLD = 0
) (
    input  logic [IN_W-1:0]      n,
    output logic [2**IN_W-1:0]   dec
);
    localparam int OUT_W = 2**IN_W;
    logic [OUT_W-1:0] hot;
    always_comb begin
        hot = OUT_W'(onehot_of(6'(n)));
        dec = (ONE_COLD != 0) ? ~hot : hot;
    end
endmodule

// File: rtl/decoder.sv
// decoder: registered binary-to-one-hot decoder with async reset to the idle code
module decoder
    import decoder_pkg::*;
#(
    parameter int IN_W     = DEC_IN_W_DEFAULT,
    parameter int ONE_COLD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_W-1:0]      N,
    output logic [2**IN_W-1:0]   result
);
    localparam int OUT_W = 2**IN_W;
    localparam logic [OUT_W-1:0] IDLE = (ONE_COLD != 0) ? '1 : '0;
    logic [OUT_W-1:0] dec;
    logic             primed;
    decoder_comb #(.IN_W(IN_W), .ONE_COLD(ONE_COLD)) u_comb (
        .n   (N),
        .dec (dec)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= IDLE;
            primed <= 1'b0;
        end else begin
            result <= dec;
            primed <= 1'b1;
        end
    end
    // primed marks that result holds a real decode rather than the reset code.
    a_onehot: assert property (@(posedge clk) disable iff (reset)
        primed |-> $onehot((ONE_COLD != 0) ? ~result : result));
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: directed checks of the one-hot and one-cold decoder variants
module tb_decoder;
    logic       clk;
    logic       reset;
    logic [2:0] N;
    logic [7:0] r_hot;
    logic [7:0] r_cold;
    int compared = 0;
    int mismatched = 0;
    logic [7:0] exp_tab [8] = '{8'b00000001, 8'b00000010, 8'b00000100, 8'b00001000,
                                8'b00010000, 8'b00100000, 8'b01000000, 8'b10000000};

    decoder #(.IN_W(3), .ONE_COLD(0)) dut_hot (
        .clk(clk), .reset(reset), .N(N), .result(r_hot)
    );
    decoder #(.IN_W(3), .ONE_COLD(1)) dut_cold (
        .clk(clk), .reset(reset), .N(N), .result(r_cold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic step(input logic [2:0] n);
        N = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        N = 3'd5;
        #1 reset = 1'b1;
        #1;
        chk("reset_async_hot", r_hot, 8'b00000000);
        chk("reset_async_cold", r_cold, 8'b11111111);
        @(posedge clk);
        #1;
        chk("reset_held_hot", r_hot, 8'b00000000);
        reset = 1'b0;
        step(3'd5);
        chk("release_n5_hot", r_hot, 8'b00100000);
        chk("release_n5_cold", r_cold, 8'b11011111);
        for (int i = 0; i < 8; i++) begin
            step(3'(i));
            chk($sformatf("sweep_n%0d", i), r_hot, exp_tab[i]);
        end
        step(3'd0);
        chk("wrap_7_to_0", r_hot, 8'b00000001);
        for (int i = 0; i < 10; i++) begin
            step(3'd3);
            chk($sformatf("hold_n3_c%0d", i), r_hot, 8'b00001000);
        end
        for (int i = 0; i < 7; i++) begin
            step(3'(i));
            chk($sformatf("presweep_n%0d", i), r_hot, exp_tab[i]);
        end
        #3 reset = 1'b1;
        #1;
        chk("midreset_async_hot", r_hot, 8'b00000000);
        chk("midreset_async_cold", r_cold, 8'b11111111);
        @(posedge clk);
        #1;
        chk("midreset_held_hot", r_hot, 8'b00000000);
        chk("midreset_held_cold", r_cold, 8'b11111111);
        reset = 1'b0;
        step(3'd2);
        chk("midreset_release_n2", r_hot, 8'b00000100);
        step(3'd4);
        chk("cold_n4", r_cold, 8'b11101111);
        chk("hot_n4", r_hot, 8'b00010000);
        step(3'd7);
        chk("cold_n7_msb", r_cold, 8'b01111111);
        step(3'd0);
        chk("cold_n0_lsb", r_cold, 8'b11111110);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
